// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MODE_EUCLID = 0;
  localparam int MODE_STEIN  = 1;

  // Width of the shared power-of-two counter k.
  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: termination detect plus either a
// subtractive-Euclid step or a binary (Stein) step.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_EUCLID,
  parameter int KW    = k_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             term,
  output logic [WIDTH-1:0] result
);

  logic             a_lt_b;
  logic [WIDTH-1:0] diff;

  // Larger minus smaller, so the subtraction can never wrap.
  assign a_lt_b = (a < b);
  assign diff   = a_lt_b ? (b - a) : (a - b);

  always_comb begin
    a_nxt  = a;
    b_nxt  = b;
    k_nxt  = k;
    term   = 1'b1;
    result = '0;
    if (a == '0) begin
      result = b;
    end else if (b == '0) begin
      result = a;
    end else if (a == b) begin
      result = a << k;
    end else begin
      term = 1'b0;
      if (MODE == MODE_STEIN) begin
        if (!a[0] && !b[0]) begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_nxt = k + KW'(1);
        end else if (!a[0]) begin
          a_nxt = a >> 1;
        end else if (!b[0]) begin
          b_nxt = b >> 1;
        end else if (a_lt_b) begin
          b_nxt = diff;
        end else begin
          a_nxt = diff;
        end
      end else begin
        if (a_lt_b) b_nxt = diff;
        else        a_nxt = diff;
      end
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Self-sequencing GCD engine with valid/ready on both sides, one
// operation in flight, and a saturating step counter.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = MODE_EUCLID,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iters
);

  localparam int KW = k_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] iters_q, iters_d;

  logic [WIDTH-1:0] a_nxt, b_nxt, result;
  logic [KW-1:0]    k_nxt;
  logic             term;

  gcd_step #(.WIDTH(WIDTH), .MODE(MODE), .KW(KW)) u_step (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_nxt  (a_nxt),
    .b_nxt  (b_nxt),
    .k_nxt  (k_nxt),
    .term   (term),
    .result (result)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    gcd_d       = gcd_q;
    iters_d     = iters_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          k_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Termination takes its own cycle and is not counted as a step.
        if (term) begin
          gcd_d       = result;
          iters_d     = cnt_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          a_d   = a_nxt;
          b_d   = b_nxt;
          k_d   = k_nxt;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      gcd_q       <= '0;
      iters_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      gcd_q       <= gcd_d;
      iters_q     <= iters_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign gcd_out   = gcd_q;
  assign iters     = iters_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: three configurations (16b Euclid, 16b Stein, 8b Euclid
// with 4-bit counter) checked every cycle against an arithmetic model.
module tb_gcd_unit;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chk_en = 1'b0;
  logic        in_valid [N];
  logic        out_ready[N];
  logic [15:0] a_in     [N];
  logic [15:0] b_in     [N];
  logic        in_ready [N];
  logic        out_valid[N];
  logic [15:0] gcd_o    [N];
  logic [15:0] it_o     [N];
  logic [15:0] g0, g1, it0, it1;
  logic [7:0]  g2;
  logic [3:0]  it2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16), .MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0]), .b_in(b_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .gcd_out(g0), .iters(it0));
  gcd_unit #(.WIDTH(16), .MODE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1]), .b_in(b_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .gcd_out(g1), .iters(it1));
  gcd_unit #(.WIDTH(8), .MODE(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2][7:0]), .b_in(b_in[2][7:0]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .gcd_out(g2), .iters(it2));

  assign gcd_o[0] = g0;
  assign gcd_o[1] = g1;
  assign gcd_o[2] = {8'h00, g2};
  assign it_o[0]  = it0;
  assign it_o[1]  = it1;
  assign it_o[2]  = {12'h000, it2};

  // ---------------- reference model ----------------
  function automatic int gcd_ref(int a, int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Subtractive Euclid performs (sum of Euclidean quotients - 1) subtractions.
  function automatic int euclid_steps(int a, int b);
    int s, t;
    if (a == 0 || b == 0) return 0;
    s = 0;
    while (b != 0) begin s += a / b; t = a % b; a = b; b = t; end
    return s - 1;
  endfunction

  function automatic int stein_steps(int a, int b);
    int s;
    s = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a % 2 == 0 && b % 2 == 0) begin a /= 2; b /= 2; end
      else if (a % 2 == 0) a /= 2;
      else if (b % 2 == 0) b /= 2;
      else if (a > b) a -= b;
      else b -= a;
      s++;
    end
    return s;
  endfunction

  function automatic int steps(int i, int a, int b);
    return (i == 1) ? stein_steps(a, b) : euclid_steps(a, b);
  endfunction

  function automatic logic [15:0] sat(int i, int n);
    int mx;
    mx = (i == 2) ? 15 : 65535;
    return 16'((n > mx) ? mx : n);
  endfunction

  function automatic int opnd(int i, logic [15:0] v);
    return (i == 2) ? int'(v & 16'h00ff) : int'(v);
  endfunction

  // 0 = idle, 1 = busy (cd steps left), 2 = result held
  int          m_st[N];
  int          m_cd[N];
  logic [15:0] m_g [N], m_it[N], p_g[N], p_it[N];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_st[i] <= 0; m_cd[i] <= 0;
        m_g[i]  <= '0; m_it[i] <= '0;
        p_g[i]  <= '0; p_it[i] <= '0;
      end else begin
        case (m_st[i])
          0: if (in_valid[i]) begin
            m_st[i] <= 1;
            m_cd[i] <= steps(i, opnd(i, a_in[i]), opnd(i, b_in[i]));
            p_g[i]  <= 16'(gcd_ref(opnd(i, a_in[i]), opnd(i, b_in[i])));
            p_it[i] <= sat(i, steps(i, opnd(i, a_in[i]), opnd(i, b_in[i])));
          end
          1: if (m_cd[i] == 0) begin
            m_st[i] <= 2; m_g[i] <= p_g[i]; m_it[i] <= p_it[i];
          end else begin
            m_cd[i] <= m_cd[i] - 1;
          end
          default: if (out_ready[i]) m_st[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk("in_ready",  i, 32'(in_ready[i]),  32'(m_st[i] == 0));
        chk("out_valid", i, 32'(out_valid[i]), 32'(m_st[i] == 2));
        chk("gcd_out",   i, 32'(gcd_o[i]),     32'(m_g[i]));
        chk("iters",     i, 32'(it_o[i]),      32'(m_it[i]));
      end
    end
  end

  // ---------------- directed operations ----------------
  // lat = rising edges from acceptance to out_valid being visible.
  task automatic op(int i, int a, int b, int eg, int ei, int el, int hold, bit chain);
    int w, lat;
    w = 0;
    @(negedge clk);
    while (!in_ready[i] && w < 3000) begin @(negedge clk); w++; end
    in_valid[i] = 1'b1; a_in[i] = 16'(a); b_in[i] = 16'(b);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid[i] = 1'b0; a_in[i] = 16'($urandom); b_in[i] = 16'($urandom);
    while (!out_valid[i] && lat < 3000) begin @(negedge clk); lat++; end
    chk("op_latency", i, 32'(lat), 32'(el));
    chk("op_gcd",     i, 32'(gcd_o[i]), 32'(eg));
    chk("op_iters",   i, 32'(it_o[i]),  32'(ei));
    if (chain) begin
      in_valid[i] = 1'b1; a_in[i] = 16'd21; b_in[i] = 16'd14;
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("bp_valid", i, 32'(out_valid[i]), 32'd1);
      chk("bp_gcd",   i, 32'(gcd_o[i]), 32'(eg));
      chk("bp_ready", i, 32'(in_ready[i]), 32'd0);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    if (chain) begin
      chk("bp_ready_after_hs", i, 32'(in_ready[i]), 32'd1);
      @(negedge clk);
      in_valid[i] = 1'b0;
      chk("bp_accepted", i, 32'(in_ready[i]), 32'd0);
      w = 0;
      while (!out_valid[i] && w < 3000) begin @(negedge clk); w++; end
      chk("bp_chain_gcd", i, 32'(gcd_o[i]), 32'd7);
      out_ready[i] = 1'b1;
      @(negedge clk);
      out_ready[i] = 1'b0;
    end
  endtask

  task automatic gen(int i, output logic [15:0] a, output logic [15:0] b);
    int sel;
    logic [15:0] m;
    sel = $urandom_range(0, 9);
    m = (i == 2) ? 16'h00ff : (16'hffff >> $urandom_range(0, 12));
    a = 16'($urandom) & m;
    b = 16'($urandom) & m;
    if (sel == 0) a = '0;
    else if (sel == 1) b = '0;
    else if (sel == 2) b = a;
    else if (sel == 3) begin a = (a << 3) & m; b = (b << 2) & m; end
    if (i == 0 && euclid_steps(int'(a), int'(b)) > 400) b = a;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
    end
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    chk("pin_gcd_48_18",    0, 32'(gcd_ref(48, 18)), 32'd6);
    chk("pin_euclid_48_18", 0, 32'(euclid_steps(48, 18)), 32'd4);
    chk("pin_stein_48_18",  1, 32'(stein_steps(48, 18)), 32'd6);
    chk("pin_euclid_255_1", 2, 32'(euclid_steps(255, 1)), 32'd254);

    op(0, 48, 18, 6, 4, 5, 0, 1'b0);
    op(1, 48, 18, 6, 6, 7, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      op(i, 0, 35, 35, 0, 1, 0, 1'b0);
      op(i, 35, 0, 35, 0, 1, 0, 1'b0);
      op(i, 0, 0, 0, 0, 1, 0, 1'b0);
      op(i, 7, 7, 7, 0, 1, 0, 1'b0);
    end

    op(0, 30, 12, 6, 3, 4, 10, 1'b1);

    // Abort a long Euclid run with an asynchronous reset pulse.
    @(negedge clk);
    in_valid[0] = 1'b1; a_in[0] = 16'd1000; b_in[0] = 16'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready",  i, 32'(in_ready[i]),  32'd1);
      chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
      chk("rst_gcd",       i, 32'(gcd_o[i]),     32'd0);
      chk("rst_iters",     i, 32'(it_o[i]),      32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 12, 8, 4, 2, 3, 0, 1'b0);

    op(2, 255, 1, 1, 15, 255, 0, 1'b0);

    // Free-running random traffic with random backpressure on all three.
    repeat (4000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        logic [15:0] ra, rb;
        gen(i, ra, rb);
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        a_in[i] = ra; b_in[i] = rb;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    repeat (500) @(negedge clk);
    for (int i = 0; i < N; i++) chk("drain_idle", i, 32'(in_ready[i]), 32'd1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
